// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings presented on op_i
//   - FSM state type used by muldiv_unit
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the multiply/divide datapath (purely combinational).
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   opnd     : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc      : current 2*XLEN accumulator
//              multiply: {partial product high, remaining multiplier bits}
//              divide  : {partial remainder, dividend bits / quotient bits}
//   acc_next : accumulator after this step
module muldiv_core #(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [XLEN-1:0]     opnd,
    input  logic [2*XLEN-1:0]   acc,
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        acc_next = acc;
        sum      = '0;
        shifted  = '0;
        diff     = '0;
        if (!is_div) begin
            // Add multiplicand to the high half when the current multiplier
            // bit is set, then shift the whole accumulator right by one; the
            // carry lands in the top bit.
            sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
            acc_next = {sum, acc[XLEN-1:1]};
        end else begin
            // Shift the next dividend bit into the remainder and trial-subtract.
            // The remainder is always below the divisor, so the shifted value
            // fits in XLEN+1 bits and a set MSB of diff means "borrow".
            // A zero divisor never borrows: quotient goes all-ones and the
            // remainder collects the dividend.
            shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
            diff    = shifted - {1'b0, opnd};
            if (!diff[XLEN]) begin
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   start_i, op_i       : issue request and operation (sampled in IDLE)
//   a_i, b_i            : operands, sampled with start_i
//   kill_i              : abort the operation in flight
//   rd_i                : MFHI/MFLO in EX (feeds the stall request)
//   hi_we_i, lo_we_i    : MTHI/MTLO strobes with wdata_i
//   busy_o, done_o      : operation in flight / HI-LO just written by an op
//   stall_o             : stall request to the hazard unit
//   hi_o, lo_o          : HI and LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    input  logic            rd_i,
    input  logic            hi_we_i,
    input  logic            lo_we_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            stall_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    md_state_t          state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*XLEN-1:0]  acc, acc_step;
    logic [XLEN-1:0]    opnd;
    logic               is_div;
    logic               neg_q;      // product sign (multiply) or quotient sign (divide)
    logic               neg_r;      // remainder sign
    logic               done;
    logic [XLEN-1:0]    hi, lo;
    logic               accept;
    logic               op_signed;
    logic               fix_write;
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    quot_fix, rem_fix;

    // Magnitude of an operand; unsigned ops pass straight through.
    // The most negative value maps onto itself, which is also its correct
    // unsigned magnitude.
    function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                  input logic                   is_signed);
        logic signed [XLEN-1:0] r;
        r = (is_signed && (v < 0)) ? -v : v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] apply_sign_wide(input logic [2*XLEN-1:0] v,
                                                          input logic            neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign op_signed = ~op_i[0];
    assign accept    = (state == ST_IDLE) && start_i && !kill_i;
    assign fix_write = (state == ST_FIX) && !kill_i;

    muldiv_core #(.XLEN(XLEN)) u_core (
        .is_div   (is_div),
        .opnd     (opnd),
        .acc      (acc),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_CALC;
            ST_CALC: begin
                if (kill_i) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == LAST_STEP) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control: iteration counter and completion pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= fix_write;
            if (accept) begin
                cnt <= '0;
            end else if (state == ST_CALC) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Datapath: operand magnitudes, result signs and the working accumulator.
    // A quotient from a zero divisor keeps its all-ones pattern, so its sign
    // fix-up is suppressed.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            acc    <= {{XLEN{1'b0}}, magnitude(a_i, op_signed)};
            opnd   <= magnitude(b_i, op_signed);
            is_div <= op_i[1];
            neg_q  <= op_signed && (a_i[XLEN-1] ^ b_i[XLEN-1]) && (!op_i[1] || (b_i != '0));
            neg_r  <= op_signed && a_i[XLEN-1];
        end else if (state == ST_CALC) begin
            acc    <= acc_step;
        end
    end

    assign prod_fix = apply_sign_wide(acc, neg_q);
    assign quot_fix = apply_sign(acc[XLEN-1:0], neg_q);
    assign rem_fix  = apply_sign(acc[2*XLEN-1:XLEN], neg_r);

    // HI/LO: operation results in FIX, MTHI/MTLO only while idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi <= '0;
            lo <= '0;
        end else if (fix_write) begin
            if (is_div) begin
                hi <= rem_fix;
                lo <= quot_fix;
            end else begin
                hi <= prod_fix[2*XLEN-1:XLEN];
                lo <= prod_fix[XLEN-1:0];
            end
        end else if (state == ST_IDLE) begin
            if (hi_we_i) hi <= wdata_i;
            if (lo_we_i) lo <= wdata_i;
        end
    end

    assign busy_o  = (state != ST_IDLE);
    assign stall_o = busy_o && (start_i || rd_i || hi_we_i || lo_we_i);
    assign done_o  = done;
    assign hi_o    = hi;
    assign lo_o    = lo;

endmodule
